// File: rtl/half_duplex_bus_ctrl.sv
// half_duplex_bus_ctrl
// Sequences one side of a shared half-duplex bus. It drives the buffer
// direction, supplies outbound words and captures inbound words. Every
// direction change gets TURN_CYC dead cycles, and each transmit burst is
// capped at MAX_BURST words so the remote side always gets a turn.
module half_duplex_bus_ctrl #(
  parameter int WIDTH     = 8,
  parameter int TURN_CYC  = 2,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  input  logic             rx_en,
  input  logic [WIDTH-1:0] bus_din,
  output logic [WIDTH-1:0] bus_dout,
  output logic             dir,
  output logic             bus_strobe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam int TURN_W  = $clog2(TURN_CYC + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  localparam logic [TURN_W-1:0]  TURN_LAST = TURN_W'(TURN_CYC - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_RX      = 2'd0,
    ST_TURN_TX = 2'd1,
    ST_TX      = 2'd2,
    ST_TURN_RX = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TURN_W-1:0]  turn_cnt_q, turn_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [WIDTH-1:0]   bus_dout_q, bus_dout_d;
  logic               bus_strobe_q, bus_strobe_d;
  logic [WIDTH-1:0]   rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               dir_q, dir_d;
  logic               accept;

  // Handshake and busy flag come straight from state and burst count so the
  // upstream sees tx_ready drop in the same cycle the burst fills up.
  assign tx_ready = (state_q == ST_TX) && (burst_cnt_q < BURST_MAX);
  assign busy     = (state_q != ST_RX);
  assign accept   = tx_valid && tx_ready;

  assign bus_dout   = bus_dout_q;
  assign bus_strobe = bus_strobe_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign dir        = dir_q;

  // Next-state logic: direction sequencing, dead-cycle and burst counting,
  // and the data/strobe values to be registered at the next edge.
  always_comb begin
    state_d      = state_q;
    turn_cnt_d   = turn_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    bus_dout_d   = bus_dout_q;
    bus_strobe_d = 1'b0;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;

    case (state_q)
      ST_RX: begin
        // The remote keeps the bus while it talks; a pending send waits.
        if (rx_en) begin
          rx_data_d  = bus_din;
          rx_valid_d = 1'b1;
        end else if (tx_valid) begin
          state_d    = ST_TURN_TX;
          turn_cnt_d = '0;
        end
      end

      ST_TURN_TX: begin
        // Enter TX even if the request vanished; TX then leaves at once.
        if (turn_cnt_q == TURN_LAST) begin
          state_d     = ST_TX;
          turn_cnt_d  = '0;
          burst_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + TURN_W'(1);
        end
      end

      ST_TX: begin
        if (accept) begin
          bus_dout_d   = tx_data;
          bus_strobe_d = 1'b1;
          burst_cnt_d  = burst_cnt_q + BURST_W'(1);
        end
        // The exit cycle can never accept, so the last strobe sees dir=1.
        if (!tx_valid || (burst_cnt_q == BURST_MAX)) begin
          state_d     = ST_TURN_RX;
          turn_cnt_d  = '0;
          burst_cnt_d = '0;
        end
      end

      ST_TURN_RX: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d    = ST_RX;
          turn_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + TURN_W'(1);
        end
      end

      default: begin
        state_d     = ST_RX;
        turn_cnt_d  = '0;
        burst_cnt_d = '0;
      end
    endcase

    // Direction is registered from the upcoming state so it is glitch-free.
    dir_d = (state_d == ST_TX);
  end

  // State and registered outputs; reset forces receive direction instantly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RX;
      turn_cnt_q   <= '0;
      burst_cnt_q  <= '0;
      bus_dout_q   <= '0;
      bus_strobe_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      dir_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      turn_cnt_q   <= turn_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      bus_dout_q   <= bus_dout_d;
      bus_strobe_q <= bus_strobe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      dir_q        <= dir_d;
    end
  end

endmodule
